fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the program-counter and instruction-address width.
REQ-002 The block SHALL have parameter START_ADDR, default 0, meaning the PC value loaded on reset and on every start.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1, a level-sampled request to begin execution at START_ADDR.
REQ-006 The block SHALL have port stall, input, 1, which freezes the PC for the current cycle.
REQ-007 The block SHALL have port halt_req, input, 1, from the decoder: the current instruction is halt.
REQ-008 The block SHALL have port br_taken, input, 1, from the decoder: the current instruction redirects the PC.
REQ-009 The block SHALL have port br_abs, input, 1, which selects the branch mode: 1 = absolute target, 0 = PC-relative.
REQ-010 The block SHALL have port br_target, input, ADDR_W, the absolute branch target.
REQ-011 The block SHALL have port br_offset, input, 4, the signed two's-complement relative offset (-8..+7).
REQ-012 The block SHALL have port inst_addr, output, ADDR_W, the address driven to the instruction ROM; it equals the PC.
REQ-013 The block SHALL have port inst_valid, output, 1, asserted when the ROM word at inst_addr is to be executed this cycle.
REQ-014 The block SHALL have port running, output, 1, asserted while in RUN or STALL.
REQ-015 The block SHALL have port halted, output, 1, asserted while in HALT.

Function
REQ-016 The block SHALL implement states IDLE, RUN, STALL and HALT, held in a registered state variable.
REQ-017 In IDLE, the block SHALL move to RUN on the edge where start=1, loading PC=START_ADDR; otherwise it holds.
REQ-018 In RUN, inst_valid SHALL equal !stall; the instruction ROM is combinational, so execution latency is zero cycles from PC to instruction.
REQ-019 In RUN, the next PC SHALL follow strict priority: stall → hold PC and go to STALL; halt_req → hold PC and go to HALT; br_taken and br_abs → br_target; br_taken and !br_abs → PC + sign-extended br_offset; otherwise → PC + 1.
REQ-020 In STALL, the PC SHALL hold, inst_valid=0, and the block SHALL return to RUN on the first edge where stall=0; the held instruction then re-executes.
REQ-021 Branch, halt and start inputs SHALL be ignored whenever stall=1.
REQ-022 All PC arithmetic SHALL be modulo 2^ADDR_W: 255+1 → 0; 1 + (-2) → 255; 254 + 7 → 5.
REQ-023 In HALT, the PC SHALL hold and inst_valid=0; start=1 SHALL reload PC=START_ADDR and go to RUN; no other input leaves HALT.
REQ-024 start SHALL have no effect while in RUN or STALL.
REQ-025 running and halted SHALL be decoded from the registered state only, with no combinational path from inputs.

Reset
REQ-026 While rst_n=0, the block SHALL be in state IDLE with PC=START_ADDR, inst_addr=START_ADDR, inst_valid=0, running=0 and halted=0, independent of clk.
REQ-027 If reset is asserted mid-operation (any state), the block SHALL abandon the operation immediately; after release, it SHALL wait in IDLE for start.
REQ-028 Reset release SHALL be synchronised internally so that the first active edge sees a stable IDLE.

Configuration
REQ-029 With macro FETCH_SEQ_RETIRE_CNT_EN defined, the block SHALL add output retire_cnt[15:0], which is cleared by reset and by start, increments on every cycle with inst_valid=1 (saturating at 16'hFFFF), and holds otherwise.
REQ-030 Without FETCH_SEQ_RETIRE_CNT_EN, the retire_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Reset, then start=1 for one cycle, with no branch or halt for 4 cycles → inst_addr 0,1,2,3; inst_valid=1 and running=1 throughout.
REQ-032 At PC=8, br_taken=1, br_abs=0 and br_offset=4'b1110 → next inst_addr=6; at PC=3, br_taken=1, br_abs=1 and br_target=8'h40 → next inst_addr=8'h40.
REQ-033 At PC=5, stall=1 for 3 cycles with br_taken=1 and halt_req=1 → inst_addr stays 5 and inst_valid=0 for 3 cycles; after that, the PC advances according to the inputs present once stall=0.
REQ-034 PC reaches 8'hFF with no branch → next inst_addr=8'h00; PC=8'hFE with relative offset +7 → next inst_addr=8'h05.
REQ-035 halt_req=1 and br_taken=1 together at PC=9 → halted=1 and inst_addr=9 held for 10 cycles; then start=1 → inst_addr=START_ADDR and running=1.
REQ-036 rst_n is pulsed low asynchronously between edges while in RUN at PC=0x22 → outputs immediately take their reset values; with FETCH_SEQ_RETIRE_CNT_EN defined, retire_cnt=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: IDLE/RUN/STALL/HALT control with branch, stall and halt handling.
// Optional retired-instruction counter enabled by defining FETCH_SEQ_RETIRE_CNT_EN.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | waiting for start after reset; PC parked at START_ADDR
//   S_RUN   | fetching; inst_valid = !stall, PC advances per decoder inputs
//   S_STALL | PC frozen, nothing executes; leaves on first stall=0 edge
//   S_HALT  | PC frozen after a halt instruction; only start leaves
module fetch_sequencer #(
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    input  logic              halt_req,
    input  logic              br_taken,
    input  logic              br_abs,
    input  logic [ADDR_W-1:0] br_target,
    input  logic [3:0]        br_offset,
    output logic [ADDR_W-1:0] inst_addr,
    output logic              inst_valid,
    output logic              running,
`ifdef FETCH_SEQ_RETIRE_CNT_EN
    output logic [15:0]       retire_cnt,
`endif
    output logic              halted
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    logic [1:0]        r_rst_sync;
    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;

    logic              w_core_en;
    logic              w_start_ok;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_pc_rel;

    // Assertion is asynchronous; release is delayed two edges so the core leaves reset cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_core_en  = r_rst_sync[1];
    assign w_start_ok = start && !stall;
    assign w_pc_inc   = r_pc + ADDR_W'(1);
    assign w_pc_rel   = r_pc + {{(ADDR_W-4){br_offset[3]}}, br_offset};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= START_ADDR;
        end else if (!w_core_en) begin
            r_state <= S_IDLE;
            r_pc    <= START_ADDR;
        end else begin
            unique case (r_state)
                S_IDLE, S_HALT: begin
                    if (w_start_ok) begin
                        r_state <= S_RUN;
                        r_pc    <= START_ADDR;
                    end
                end
                S_RUN: begin
                    if (stall) begin
                        r_state <= S_STALL;
                    end else if (halt_req) begin
                        r_state <= S_HALT;
                    end else if (br_taken && br_abs) begin
                        r_pc <= br_target;
                    end else if (br_taken) begin
                        r_pc <= w_pc_rel;
                    end else begin
                        r_pc <= w_pc_inc;
                    end
                end
                S_STALL: begin
                    // PC is kept so the stalled instruction re-executes on return to RUN.
                    if (!stall) begin
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_pc    <= START_ADDR;
                end
            endcase
        end
    end

    assign inst_addr  = r_pc;
    assign inst_valid = (r_state == S_RUN) && !stall;
    assign running    = (r_state == S_RUN) || (r_state == S_STALL);
    assign halted     = (r_state == S_HALT);

`ifdef FETCH_SEQ_RETIRE_CNT_EN
    logic [15:0] r_retire_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_cnt <= '0;
        end else if (!w_core_en) begin
            r_retire_cnt <= '0;
        end else if (((r_state == S_IDLE) || (r_state == S_HALT)) && w_start_ok) begin
            r_retire_cnt <= '0;
        end else if (inst_valid && (r_retire_cnt != 16'hFFFF)) begin
            r_retire_cnt <= r_retire_cnt + 16'd1;
        end
    end

    assign retire_cnt = r_retire_cnt;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios then random traffic, checked against
// a cycle-level behavioural model of the sequencing rules.
module tb_fetch_sequencer;

    localparam int ADDR_W = 8;
    localparam int START  = 0;
    localparam int M_IDLE = 0, M_RUN = 1, M_STALL = 2, M_HALT = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, stall, halt_req, br_taken, br_abs;
    logic [ADDR_W-1:0] br_target;
    logic [3:0]        br_offset;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_valid, running, halted;
`ifdef FETCH_SEQ_RETIRE_CNT_EN
    logic [15:0]       retire_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int m_mode, m_pc, m_cnt;

    fetch_sequencer #(.ADDR_W(ADDR_W), .START_ADDR(8'(START))) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stall      (stall),
        .halt_req   (halt_req),
        .br_taken   (br_taken),
        .br_abs     (br_abs),
        .br_target  (br_target),
        .br_offset  (br_offset),
        .inst_addr  (inst_addr),
        .inst_valid (inst_valid),
        .running    (running),
`ifdef FETCH_SEQ_RETIRE_CNT_EN
        .retire_cnt (retire_cnt),
`endif
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("inst_addr", 32'(inst_addr), 32'(m_pc));
        chk("inst_valid", 32'(inst_valid), 32'((m_mode == M_RUN) && !stall));
        chk("running", 32'(running), 32'((m_mode == M_RUN) || (m_mode == M_STALL)));
        chk("halted", 32'(halted), 32'(m_mode == M_HALT));
`ifdef FETCH_SEQ_RETIRE_CNT_EN
        chk("retire_cnt", 32'(retire_cnt), 32'(m_cnt));
`endif
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_pc   = START;
        m_cnt  = 0;
    endtask

    // Reference: advance one clock using the inputs visible before the edge.
    task automatic model_edge();
        int off;
        bit valid;
        valid = (m_mode == M_RUN) && !stall;
        off   = br_offset[3] ? int'(br_offset) - 16 : int'(br_offset);
        if ((m_mode == M_IDLE || m_mode == M_HALT) && start && !stall) m_cnt = 0;
        else if (valid && m_cnt < 65535) m_cnt = m_cnt + 1;
        case (m_mode)
            M_IDLE, M_HALT: if (start && !stall) begin m_mode = M_RUN; m_pc = START; end
            M_RUN: begin
                if (stall)                  m_mode = M_STALL;
                else if (halt_req)          m_mode = M_HALT;
                else if (br_taken && br_abs) m_pc = int'(br_target);
                else if (br_taken)          m_pc = (m_pc + off + 256) % 256;
                else                        m_pc = (m_pc + 1) % 256;
            end
            default: if (!stall) m_mode = M_RUN;
        endcase
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic quiet();
        start = 0; stall = 0; halt_req = 0; br_taken = 0; br_abs = 0;
        br_target = '0; br_offset = '0;
    endtask

    task automatic branch_abs(input logic [7:0] t);
        br_taken = 1; br_abs = 1; br_target = t;
        step();
        quiet();
    endtask

    initial begin
        quiet();
        rst_n = 0;
        model_reset();
        #12;
        check_outputs();
        #6 rst_n = 1;
        @(posedge clk); #1;
        repeat (3) step();

        // start, then straight-line fetch 0,1,2,3 and on to 8
        start = 1; step(); start = 0;
        repeat (8) step();
        chk("pc_at_8", 32'(inst_addr), 32'd8);
        br_taken = 1; br_abs = 0; br_offset = 4'b1110; step(); quiet();
        chk("rel_minus2", 32'(inst_addr), 32'd6);
        branch_abs(8'h03);
        branch_abs(8'h40);
        chk("abs_40", 32'(inst_addr), 32'h40);

        // stall at 5 with branch and halt pending
        branch_abs(8'h05);
        stall = 1; br_taken = 1; halt_req = 1; br_abs = 1; br_target = 8'h77;
        repeat (3) step();
        chk("stall_hold", 32'(inst_addr), 32'd5);
        stall = 0; halt_req = 0; br_target = 8'h10;
        step(); step(); quiet();
        chk("post_stall_br", 32'(inst_addr), 32'h10);

        // wrap-around
        branch_abs(8'hFF);
        step();
        chk("wrap_ff", 32'(inst_addr), 32'h00);
        branch_abs(8'hFE);
        br_taken = 1; br_abs = 0; br_offset = 4'b0111; step(); quiet();
        chk("wrap_fe_p7", 32'(inst_addr), 32'h05);

        // halt with simultaneous branch, then restart
        branch_abs(8'h09);
        halt_req = 1; br_taken = 1; step(); quiet();
        for (int i = 0; i < 10; i++) begin
            br_taken = 1'($urandom); halt_req = 1'($urandom); stall = 1'($urandom);
            br_abs = 1'($urandom); br_target = 8'($urandom);
            step();
        end
        quiet();
        chk("halt_pc", 32'(inst_addr), 32'd9);
        start = 1; step(); quiet();
        chk("restart_pc", 32'(inst_addr), 32'(START));
        chk("restart_run", 32'(running), 32'd1);

        // asynchronous reset mid-run at 0x22
        branch_abs(8'h22);
        chk("pc_22", 32'(inst_addr), 32'h22);
        #2 rst_n = 0;
        model_reset();
        #1;
        check_outputs();
        #2 rst_n = 1;
        @(posedge clk); #1;
        repeat (3) step();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            start     = ($urandom_range(0, 7) == 0);
            stall     = ($urandom_range(0, 3) == 0);
            halt_req  = ($urandom_range(0, 24) == 0);
            br_taken  = ($urandom_range(0, 3) == 0);
            br_abs    = 1'($urandom);
            br_target = 8'($urandom);
            br_offset = 4'($urandom);
            step();
        end
        quiet();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
